// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester (fetch / data) arbiter onto a shared memory bus
// Data access wins over fetch; each grant is held until ack, timeout or flush-drop.
module bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_sel,
  input  logic              if_hold,
  input  logic              mem_hold,
  input  logic              flush,
  output logic              bus_cyc,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_IF_BUSY, ST_MEM_BUSY, ST_IF_DROP, ST_IF_DONE, ST_MEM_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic              r_cyc;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic              w_timeout;

  // Abort fires on the last allowed wait cycle, so the counter never reaches TIMEOUT_CYC.
  assign w_timeout = (r_cnt == LP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= 4'h0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_state <= ST_MEM_BUSY;
            r_cyc   <= 1'b1;
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_sel   <= mem_sel;
            r_cnt   <= 8'd0;
          end else if (if_req && !flush) begin
            r_state <= ST_IF_BUSY;
            r_cyc   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= '0;
            r_sel   <= 4'hF;
            r_cnt   <= 8'd0;
          end
        end
        ST_IF_BUSY: begin
          if (bus_ack) begin
            r_cyc <= 1'b0;
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_if_rdata <= bus_rdata;
              r_state    <= ST_IF_DONE;
            end
          end else if (flush) begin
            r_state <= ST_IF_DROP;
            r_cnt   <= 8'd0;
          end else if (w_timeout) begin
            r_cyc      <= 1'b0;
            r_if_rdata <= '0;
            r_err      <= 1'b1;
            r_state    <= ST_IF_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_MEM_BUSY: begin
          if (bus_ack) begin
            r_cyc       <= 1'b0;
            r_mem_rdata <= bus_rdata;
            r_state     <= ST_MEM_DONE;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_mem_rdata <= '0;
            r_err       <= 1'b1;
            r_state     <= ST_MEM_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_IF_DROP: begin
          // The bus cycle must still complete; its data belongs to a flushed fetch.
          if (bus_ack) begin
            r_cyc   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_IF_DONE: begin
          if (flush || !if_hold) r_state <= ST_IDLE;
        end
        ST_MEM_DONE: begin
          if (!mem_hold) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_cyc           = r_cyc;
  assign bus_we            = r_we;
  assign bus_addr          = r_addr;
  assign bus_wdata         = r_wdata;
  assign bus_sel           = r_sel;
  assign if_rdata          = r_if_rdata;
  assign mem_rdata         = r_mem_rdata;
  assign bus_err           = r_err;
  assign stallreq_from_if  = if_req && (r_state != ST_IF_DONE);
  assign stallreq_from_mem = mem_req && (r_state != ST_MEM_DONE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, if_hold, mem_hold, flush, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic        bus_cyc, bus_we, stallreq_from_if, stallreq_from_mem, bus_err;
  logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
  logic [3:0]  bus_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc, n_err;
  logic [31:0] held;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .if_hold(if_hold), .mem_hold(mem_hold), .flush(flush),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bus_cyc"},   64'(bus_cyc),   64'd0);
    check({tag, " bus_we"},    64'(bus_we),    64'd0);
    check({tag, " bus_addr"},  64'(bus_addr),  64'd0);
    check({tag, " bus_wdata"}, 64'(bus_wdata), 64'd0);
    check({tag, " bus_sel"},   64'(bus_sel),   64'd0);
    check({tag, " if_rdata"},  64'(if_rdata),  64'd0);
    check({tag, " mem_rdata"}, 64'(mem_rdata), 64'd0);
    check({tag, " bus_err"},   64'(bus_err),   64'd0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0; if_hold = 0; mem_hold = 0; flush = 0; bus_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0; bus_rdata = 0;
    #2;
    check_reset_outputs("reset");
    tick(); tick();
    rst = 1'b0;

    // Fetch, ack after two wait cycles
    if_req = 1; if_addr = 32'h0000_0100;
    #1;
    check("f1 idle stall_if", 64'(stallreq_from_if), 64'd1);
    check("f1 idle bus_cyc", 64'(bus_cyc), 64'd0);
    n_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_ack = (i == 2); bus_rdata = (i == 2) ? 32'h3C01_0001 : 32'hFFFF_FFFF;
      #1;
      n_cyc += int'(bus_cyc);
      check("f1 busy stall_if", 64'(stallreq_from_if), 64'd1);
      check("f1 busy addr", 64'(bus_addr), 64'h100);
      check("f1 busy we", 64'(bus_we), 64'd0);
    end
    tick();
    bus_ack = 0;
    #1;
    check("f1 done stall_if", 64'(stallreq_from_if), 64'd0);
    check("f1 done bus_cyc", 64'(bus_cyc), 64'd0);
    check("f1 if_rdata", 64'(if_rdata), 64'h3C01_0001);
    check("f1 bus_cyc count", 64'(n_cyc), 64'd3);
    if_req = 0;
    tick();
    #1;
    check("f1 idle after", 64'(bus_cyc), 64'd0);

    // Simultaneous requests: data write first, then fetch
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
    if_req = 1; if_addr = 32'h104;
    tick();
    #1;
    check("arb mem cyc", 64'(bus_cyc), 64'd1);
    check("arb mem we", 64'(bus_we), 64'd1);
    check("arb mem addr", 64'(bus_addr), 64'h200);
    check("arb mem wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
    check("arb mem sel", 64'(bus_sel), 64'hF);
    check("arb stall_if in mem", 64'(stallreq_from_if), 64'd1);
    tick();
    bus_ack = 1; bus_rdata = 32'h1111_1111;
    #1;
    check("arb stall_if at ack", 64'(stallreq_from_if), 64'd1);
    tick();
    bus_ack = 0;
    #1;
    check("arb mem done stall_mem", 64'(stallreq_from_mem), 64'd0);
    check("arb mem done stall_if", 64'(stallreq_from_if), 64'd1);
    check("arb mem done cyc", 64'(bus_cyc), 64'd0);
    check("arb mem_rdata", 64'(mem_rdata), 64'h1111_1111);
    mem_req = 0;
    tick();
    #1;
    check("arb idle cyc", 64'(bus_cyc), 64'd0);
    tick();
    bus_ack = 1; bus_rdata = 32'h2222_2222;
    #1;
    check("arb if cyc", 64'(bus_cyc), 64'd1);
    check("arb if we", 64'(bus_we), 64'd0);
    check("arb if addr", 64'(bus_addr), 64'h104);
    tick();
    bus_ack = 0; if_req = 0;
    #1;
    check("arb if_rdata", 64'(if_rdata), 64'h2222_2222);
    tick();

    // Flush mid-fetch, ack three cycles later
    if_req = 1; if_addr = 32'h108;
    tick();
    flush = 1;
    #1;
    check("fl busy cyc", 64'(bus_cyc), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      flush = 0; if_req = 0;
      bus_ack = (i == 2); bus_rdata = 32'hBAD0_BAD0;
      #1;
      check("fl drop cyc", 64'(bus_cyc), 64'd1);
    end
    tick();
    bus_ack = 0;
    #1;
    check("fl after cyc", 64'(bus_cyc), 64'd0);
    check("fl if_rdata kept", 64'(if_rdata), 64'h2222_2222);
    if_req = 1; if_addr = 32'h10C;
    tick();
    #1;
    check("fl idle regrant", 64'(bus_cyc), 64'd1);
    check("fl idle regrant addr", 64'(bus_addr), 64'h10C);
    bus_ack = 1; bus_rdata = 32'h3333_3333;
    tick();
    bus_ack = 0; if_req = 0;
    tick();

    // mem_hold keeps MEM_DONE for four cycles
    mem_req = 1; mem_we = 0; mem_addr = 32'h300;
    tick();
    bus_ack = 1; bus_rdata = 32'h5A5A_0001; mem_hold = 1;
    tick();
    bus_ack = 0; bus_rdata = 32'h0;
    held = 32'h5A5A_0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold stall_mem", 64'(stallreq_from_mem), 64'd0);
      check("hold cyc", 64'(bus_cyc), 64'd0);
      check("hold mem_rdata", 64'(mem_rdata), 64'(held));
      tick();
    end
    mem_hold = 0;
    #1;
    check("hold last stall_mem", 64'(stallreq_from_mem), 64'd0);
    tick();
    #1;
    check("hold idle stall_mem", 64'(stallreq_from_mem), 64'd1);
    check("hold idle cyc", 64'(bus_cyc), 64'd0);
    mem_req = 0;
    tick();

    // Timeout with no ack
    mem_req = 1; mem_addr = 32'h400;
    tick();
    n_cyc = 0; n_err = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_cyc += int'(bus_cyc);
      n_err += int'(bus_err);
      if (bus_err) check("to mem_rdata", 64'(mem_rdata), 64'd0);
      if (i > 0 && !bus_cyc) mem_req = 0;
      tick();
    end
    check("to bus_cyc count", 64'(n_cyc), 64'd8);
    check("to err pulses", 64'(n_err), 64'd1);

    // Asynchronous reset during MEM_BUSY
    mem_req = 1; mem_we = 1; mem_addr = 32'h500; mem_wdata = 32'h1234_5678; mem_sel = 4'b0011;
    tick();
    #1;
    check("ar busy cyc", 64'(bus_cyc), 64'd1);
    rst = 1;
    #1;
    check_reset_outputs("async");
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    tick();
    mem_req = 0; bus_ack = 0; rst = 0;
    #1;
    check("ar no capture", 64'(mem_rdata), 64'd0);
    if_req = 1; if_addr = 32'h600;
    tick();
    #1;
    check("ar restart cyc", 64'(bus_cyc), 64'd1);
    check("ar restart addr", 64'(bus_addr), 64'h600);
    if_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum number of cycles to wait for bus_ack before an access is aborted; range 1..255.
REQ-004 The block SHALL use one clock and one reset: clk is the clock; rst is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 if_req, if_addr  in  1, ADDR_W  instruction-fetch read request and its address.
REQ-008 mem_req, mem_we, mem_addr, mem_wdata, mem_sel  in  1, 1, ADDR_W, DATA_W, 4  data-access request: write enable, address, write data, byte lanes.
REQ-009 if_hold, mem_hold  in  1, 1  pipeline stall for the fetch stage and the memory stage (stall[1], stall[4]).
REQ-010 flush  in  1  pipeline flush; discards the fetch access.
REQ-011 bus_cyc, bus_we, bus_addr, bus_wdata, bus_sel  out  1, 1, ADDR_W, DATA_W, 4  shared memory-bus request.
REQ-012 bus_ack, bus_rdata  in  1, DATA_W  bus completion strobe and read data.
REQ-013 if_rdata, mem_rdata  out  DATA_W  registered read data returned to each requester.
REQ-014 stallreq_from_if, stallreq_from_mem  out  1  stall requests to the pipeline controller.
REQ-015 bus_err  out  1  one-cycle pulse on access timeout.

Function
REQ-016 FSM states: IDLE, IF_BUSY, MEM_BUSY, IF_DROP, IF_DONE, MEM_DONE.
REQ-017 IDLE: mem_req=1 -> MEM_BUSY; else if_req=1 and flush=0 -> IF_BUSY; MEM has priority when both are asserted.
REQ-018 On entering a BUSY state, bus_addr/bus_we/bus_wdata/bus_sel SHALL be latched from the granted requester and held stable until completion; bus_we=0 for fetch.
REQ-019 bus_cyc=1 only in IF_BUSY, MEM_BUSY, IF_DROP.
REQ-020 BUSY with bus_ack=1 in cycle N: bus_rdata captured into the requester's rdata register at end of N; state -> the matching DONE in N+1; bus_cyc=0 in N+1.
REQ-021 IF_DONE / MEM_DONE: stay while the matching hold is 1; return to IDLE on the first cycle where hold=0.
REQ-022 stallreq_from_mem=1 whenever mem_req=1 and state is not MEM_DONE; stallreq_from_if=1 whenever if_req=1 and state is not IF_DONE; both 0 in DONE and IDLE with no request.
REQ-023 Minimum access latency: request in IDLE at cycle 0, bus_ack in cycle 1 -> DONE in cycle 2, stall low in cycle 2; read data valid from cycle 2.
REQ-024 flush=1 in IF_BUSY without bus_ack -> IF_DROP; IF_DROP holds bus_cyc until bus_ack, then -> IDLE, and data is discarded (if_rdata unchanged).
REQ-025 flush=1 in IF_BUSY with bus_ack in the same cycle -> IDLE, data discarded; flush in IF_DONE -> IDLE.
REQ-026 flush SHALL NOT affect MEM_BUSY or MEM_DONE.
REQ-027 An 8-bit wait counter clears on entering a BUSY/DROP state and increments each cycle without bus_ack; at count == TIMEOUT_CYC-1 with no ack, the access aborts: rdata register <= 0, bus_err pulses 1 cycle, state -> matching DONE (IF_DROP -> IDLE); the counter SHALL NOT wrap.
REQ-028 A requester dropping its req while BUSY SHALL NOT abort the bus cycle; completion proceeds, and DONE exits to IDLE next cycle.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, bus_cyc=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, if_rdata=0, mem_rdata=0, bus_err=0, counter=0, regardless of clk.
REQ-030 Reset mid-access SHALL abandon the bus cycle with no data capture; the first request after release starts from IDLE.

Verification
REQ-031 Fetch: if_req=1, if_addr=0x00000100, ack after 2 wait cycles with rdata=0x3C010001 -> bus_cyc 3 cycles, if_rdata=0x3C010001, stallreq_from_if low exactly in IF_DONE.
REQ-032 Simultaneous if_req and mem_req (write, addr 0x200, wdata 0xDEADBEEF, sel 4'b1111) -> MEM access first with bus_we=1, then fetch; stallreq_from_if high throughout the MEM access.
REQ-033 Flush during fetch with ack 3 cycles later -> IF_DROP, bus_cyc held until ack, if_rdata unchanged, state IDLE afterwards.
REQ-034 mem_hold=1 for 4 cycles after ack -> state stays MEM_DONE for 4 cycles, mem_rdata stable, no new bus_cyc.
REQ-035 No ack with TIMEOUT_CYC=8 -> abort after 8 bus_cyc cycles, bus_err pulses once, mem_rdata=0.
REQ-036 rst asserted between clock edges during MEM_BUSY -> bus_cyc=0 and all outputs at reset values before the next edge.
